// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: byte-stream command decoder that turns UART 'W'/'R' frames into 16-bit bus cycles.
// Replies 0x2B on write, two read-data bytes on read, 0x3F on an unknown opcode.
module uart_bus_bridge #(
    parameter int TIMEOUT = 40000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] address,
    output logic [15:0] dout,
    input  logic [15:0] din,
    output logic        rnw,
    output logic        bus_req,
    input  logic        bus_ack,
    output logic        halt,
    output logic        err_overrun
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ADDR_H, ADDR_L, DATA_H, DATA_L, BUS, TX_H, TX_L} state_t;

    state_t         state_q;
    logic [CW-1:0]  tmo_q;
    logic [15:0]    address_q, dout_q;
    logic [7:0]     tx_data_q, rd_lo_q;
    logic           rnw_q, bus_req_q, tx_valid_q, halt_q, err_q;
    logic           waiting, busy, tmo_hit;

    always_comb begin
        waiting = state_q inside {ADDR_H, ADDR_L, DATA_H, DATA_L};
        busy    = state_q inside {BUS, TX_H, TX_L};
        tmo_hit = waiting && !rx_valid && (tmo_q == TMO_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tmo_q      <= '0;
            address_q  <= '0;
            dout_q     <= '0;
            tx_data_q  <= '0;
            rd_lo_q    <= '0;
            rnw_q      <= 1'b1;
            bus_req_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            halt_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (rx_valid)
                tmo_q <= '0;
            else if (waiting && tmo_q != TMO_MAX)
                tmo_q <= tmo_q + 1'b1;
            if (rx_valid && busy)
                err_q <= 1'b1;
            // A byte on the expiry edge wins over the timeout (tmo_hit needs !rx_valid)
            if (tmo_hit) begin
                state_q <= IDLE;
                halt_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (rx_valid) begin
                        halt_q <= 1'b1;
                        if (rx_data == 8'h57 || rx_data == 8'h52) begin
                            rnw_q   <= (rx_data == 8'h52);
                            state_q <= ADDR_H;
                        end else begin
                            tx_data_q  <= 8'h3F;
                            tx_valid_q <= 1'b1;
                            state_q    <= TX_L;
                        end
                    end
                    ADDR_H: if (rx_valid) begin
                        address_q[15:8] <= rx_data;
                        state_q         <= ADDR_L;
                    end
                    ADDR_L: if (rx_valid) begin
                        address_q[7:0] <= rx_data;
                        bus_req_q      <= rnw_q;
                        state_q        <= rnw_q ? BUS : DATA_H;
                    end
                    DATA_H: if (rx_valid) begin
                        dout_q[15:8] <= rx_data;
                        state_q      <= DATA_L;
                    end
                    DATA_L: if (rx_valid) begin
                        dout_q[7:0] <= rx_data;
                        bus_req_q   <= 1'b1;
                        state_q     <= BUS;
                    end
                    BUS: if (bus_ack) begin
                        bus_req_q  <= 1'b0;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= rnw_q ? din[15:8] : 8'h2B;
                        rd_lo_q    <= din[7:0];
                        state_q    <= rnw_q ? TX_H : TX_L;
                    end
                    TX_H: if (tx_ready) begin
                        tx_data_q <= rd_lo_q;
                        state_q   <= TX_L;
                    end
                    TX_L: if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        halt_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign address     = address_q;
    assign dout        = dout_q;
    assign rnw         = rnw_q;
    assign bus_req     = bus_req_q;
    assign halt        = halt_q;
    assign err_overrun = err_q;
endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb_uart_bus_bridge: directed-vector bench for uart_bus_bridge with hand-computed expectations.
module tb_uart_bus_bridge;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] address, dout, din;
    logic        rnw, bus_req, bus_ack, halt, err_overrun;

    int vectors = 0;
    int miscompares = 0;

    uart_bus_bridge #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .address(address), .dout(dout), .din(din),
        .rnw(rnw), .bus_req(bus_req), .bus_ack(bus_ack),
        .halt(halt), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
        din = '0; bus_ack = 1'b0;
        step(); step();
        check("rst_halt", halt, 0);
        check("rst_bus_req", bus_req, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_rnw", rnw, 1);
        check("rst_address", address, 0);
        check("rst_dout", dout, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_err", err_overrun, 0);
        reset = 1'b0;

        // write 0x1234 <= 0xABCD, bus_ack tied high
        bus_ack = 1'b1;
        send(8'h57);
        check("wr_halt_first", halt, 1);
        send(8'h12); send(8'h34); send(8'hAB);
        check("wr_no_req_early", bus_req, 0);
        send(8'hCD);
        check("wr_bus_req", bus_req, 1);
        check("wr_rnw", rnw, 0);
        check("wr_address", address, 16'h1234);
        check("wr_dout", dout, 16'hABCD);
        step();
        check("wr_req_one_cycle", bus_req, 0);
        check("wr_tx_valid", tx_valid, 1);
        check("wr_tx_2b", tx_data, 8'h2B);
        check("wr_halt_tx", halt, 1);
        tx_ready = 1'b1;
        step();
        check("wr_tx_done", tx_valid, 0);
        check("wr_halt_done", halt, 0);
        tx_ready = 1'b0; bus_ack = 1'b0;

        // read 0x0FFE, ack after 3 cycles, tx stalled 5 cycles
        din = 16'hBEEF;
        send(8'h52); send(8'h0F); send(8'hFE);
        check("rd_rnw", rnw, 1);
        check("rd_address", address, 16'h0FFE);
        for (int i = 0; i < 3; i++) begin
            check("rd_req_wait", bus_req, 1);
            step();
        end
        check("rd_req_wait", bus_req, 1);
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0; din = 16'h0000;
        check("rd_req_drop", bus_req, 0);
        for (int i = 0; i < 5; i++) begin
            check("rd_stall_valid", tx_valid, 1);
            check("rd_stall_data", tx_data, 8'hBE);
            step();
        end
        tx_ready = 1'b1;
        step();
        check("rd_tx_lo_valid", tx_valid, 1);
        check("rd_tx_lo", tx_data, 8'hEF);
        step();
        check("rd_tx_done", tx_valid, 0);
        check("rd_halt_done", halt, 0);
        tx_ready = 1'b0;

        // unknown opcode
        send(8'h41);
        check("bad_tx_valid", tx_valid, 1);
        check("bad_tx_3f", tx_data, 8'h3F);
        check("bad_no_req", bus_req, 0);
        check("bad_halt", halt, 1);
        tx_ready = 1'b1;
        step();
        check("bad_tx_done", tx_valid, 0);
        check("bad_halt_done", halt, 0);
        tx_ready = 1'b0;

        // byte on the expiry edge is kept, then a real timeout
        send(8'h57);
        for (int i = 0; i < 15; i++) step();
        check("tmo_edge_halt", halt, 1);
        send(8'h12);
        check("tmo_edge_taken", halt, 1);
        for (int i = 0; i < 15; i++) step();
        check("tmo_before", halt, 1);
        step();
        check("tmo_expired", halt, 0);
        for (int i = 0; i < 4; i++) begin
            check("tmo_no_req", bus_req, 0);
            check("tmo_no_reply", tx_valid, 0);
            step();
        end
        bus_ack = 1'b1; din = 16'h1357;
        send(8'h52);
        check("tmo_next_opcode", halt, 1);
        send(8'h00); send(8'h02);
        check("tmo_rd_req", bus_req, 1);
        check("tmo_rd_rnw", rnw, 1);
        check("tmo_rd_addr", address, 16'h0002);
        step();
        check("tmo_rd_hi", tx_data, 8'h13);
        tx_ready = 1'b1;
        step();
        check("tmo_rd_lo", tx_data, 8'h57);
        step();
        check("tmo_rd_done", halt, 0);
        tx_ready = 1'b0; bus_ack = 1'b0;

        // overrun during the bus wait
        send(8'h57); send(8'h00); send(8'h10); send(8'h55); send(8'hAA);
        check("ovr_req", bus_req, 1);
        check("ovr_err_before", err_overrun, 0);
        send(8'h99);
        check("ovr_err", err_overrun, 1);
        check("ovr_req_hold", bus_req, 1);
        check("ovr_address", address, 16'h0010);
        check("ovr_dout", dout, 16'h55AA);
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        check("ovr_tx_2b", tx_data, 8'h2B);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        check("ovr_sticky", err_overrun, 1);
        check("ovr_idle", halt, 0);

        // reset while a read reply is pending in TX_H
        bus_ack = 1'b1; din = 16'hABCD;
        send(8'h52); send(8'h00); send(8'h20);
        step();
        bus_ack = 1'b0;
        check("rst_tx_h_valid", tx_valid, 1);
        check("rst_tx_h_data", tx_data, 8'hAB);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_tx_valid", tx_valid, 0);
        check("rst_mid_err", err_overrun, 0);
        check("rst_mid_halt", halt, 0);
        check("rst_mid_rnw", rnw, 1);
        check("rst_mid_addr", address, 0);
        send(8'h41);
        check("rst_first_opcode", tx_data, 8'h3F);
        tx_ready = 1'b1;
        step();
        check("rst_first_done", halt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
